// File: rtl/multi_go_delay_pkg.sv
// Shared definitions for the multi-channel go/delay block:
// per-channel FSM state encoding and the default delay counter width.
package multi_go_delay_pkg;

   localparam int DEF_DLY_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } ch_state_t;

endpackage

// File: rtl/go_delay_ch.sv
// One go/delay channel: IDLE -> RUN for delay_cfg cycles -> one-cycle DONE.
// Kill always wins over go; a zero delay is stretched to one cycle.
module go_delay_ch
   import multi_go_delay_pkg::*;
#(
   parameter int DLY_W  = DEF_DLY_W,
   parameter int RETRIG = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             go,
   input  logic             kill,
   input  logic [DLY_W-1:0] delay_cfg,
   output logic             busy,
   output logic             done
);

   ch_state_t        state;
   ch_state_t        state_nxt;
   logic [DLY_W-1:0] cnt;
   logic [DLY_W-1:0] cnt_nxt;
   logic [DLY_W-1:0] load_val;
   logic             start;

   assign load_val = (delay_cfg == '0) ? DLY_W'(1) : delay_cfg;
   assign start    = go & ~kill;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The counter reaches 1 on the last RUN cycle, so DONE follows exactly delay_cfg edges after the load.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_RUN;
               cnt_nxt   = load_val;
            end
         end
         ST_RUN: begin
            if (kill) begin
               state_nxt = ST_IDLE;
            end else if ((RETRIG != 0) && go) begin
               cnt_nxt = load_val;
            end else if (cnt == DLY_W'(1)) begin
               state_nxt = ST_DONE;
            end else begin
               cnt_nxt = cnt - DLY_W'(1);
            end
         end
         ST_DONE: begin
            if (start) begin
               state_nxt = ST_RUN;
               cnt_nxt   = load_val;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_RUN);
      done = (state == ST_DONE);
   end

endmodule

// File: rtl/multi_go_delay.sv
// NUM_CH independent go/delay channels plus sticky per-channel kill flags
// and their combined OR.
module multi_go_delay
   import multi_go_delay_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int DLY_W  = DEF_DLY_W,
   parameter int RETRIG = 0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_CH-1:0]       go,
   input  logic [NUM_CH-1:0]       kill,
   input  logic [NUM_CH-1:0]       kill_clr,
   input  logic [NUM_CH*DLY_W-1:0] delay_cfg,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH-1:0]       kill_ltchd,
   output logic                    kill_any
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      go_delay_ch #(
         .DLY_W  (DLY_W),
         .RETRIG (RETRIG)
      ) u_ch (
         .clk       (clk),
         .reset_n   (reset_n),
         .go        (go[i]),
         .kill      (kill[i]),
         .delay_cfg (delay_cfg[i*DLY_W +: DLY_W]),
         .busy      (busy[i]),
         .done      (done[i])
      );
   end

   // Kill flags ignore channel state; a new kill beats a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kill_ltchd <= '0;
      end else begin
         kill_ltchd <= (kill_ltchd & ~kill_clr) | kill;
      end
   end

   assign kill_any = |kill_ltchd;

endmodule

// File: tb/tb_multi_go_delay.sv
// Bench for multi_go_delay: a RETRIG=0 and a RETRIG=1 instance side by side,
// with expected done pulses queued at go time and matched as they appear.
module tb_multi_go_delay;

   typedef struct {
      int dut;
      int ch;
      int cyc;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic [2:0]  a_go, a_kill, a_clr, a_busy, a_done, a_kl;
   logic [2:0]  b_go, b_kill, b_clr, b_busy, b_done, b_kl;
   logic [23:0] a_cfg, b_cfg;
   logic        a_ka, b_ka;

   exp_t sb[$];
   int   now;
   int   total;
   int   bad;
   int   e;

   multi_go_delay #(.NUM_CH(3), .DLY_W(8), .RETRIG(0)) dut_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .go         (a_go),
      .kill       (a_kill),
      .kill_clr   (a_clr),
      .delay_cfg  (a_cfg),
      .busy       (a_busy),
      .done       (a_done),
      .kill_ltchd (a_kl),
      .kill_any   (a_ka)
   );

   multi_go_delay #(.NUM_CH(3), .DLY_W(8), .RETRIG(1)) dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .go         (b_go),
      .kill       (b_kill),
      .kill_clr   (b_clr),
      .delay_cfg  (b_cfg),
      .busy       (b_busy),
      .done       (b_done),
      .kill_ltchd (b_kl),
      .kill_any   (b_ka)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, now);
      end
   endtask

   task automatic applyStimulus(input int dut, input logic [2:0] go_v,
                                input logic [2:0] kill_v, input logic [2:0] clr_v);
      if (dut == 0) begin
         a_go = go_v; a_kill = kill_v; a_clr = clr_v;
      end else begin
         b_go = go_v; b_kill = kill_v; b_clr = clr_v;
      end
   endtask

   task automatic setCfg(input int dut, input int ch, input logic [7:0] val);
      if (dut == 0) a_cfg[ch*8 +: 8] = val;
      else          b_cfg[ch*8 +: 8] = val;
   endtask

   task automatic pushExp(input int dut, input int ch, input int cyc);
      exp_t x;
      x.dut = dut; x.ch = ch; x.cyc = cyc;
      sb.push_back(x);
   endtask

   // Any done bit, or any expectation due this edge, becomes one comparison.
   task automatic monitorDone();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 3; c++) begin
            logic dbit;
            logic expd;
            int   idx;
            dbit = (d == 0) ? a_done[c] : b_done[c];
            idx  = -1;
            expd = 1'b0;
            for (int k = 0; k < sb.size(); k++)
               if (idx < 0 && sb[k].dut == d && sb[k].ch == c) idx = k;
            if (idx >= 0 && sb[idx].cyc == now) expd = 1'b1;
            if (dbit || expd) begin
               checkOutput($sformatf("done_d%0d_c%0d", d, c), {31'd0, dbit}, {31'd0, expd});
               if (expd) sb.delete(idx);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      now++;
      monitorDone();
   endtask

   initial begin
      total = 0; bad = 0; now = 0;
      reset_n = 1'b0;
      a_cfg = '0; b_cfg = '0;
      applyStimulus(0, 3'b000, 3'b000, 3'b000);
      applyStimulus(1, 3'b000, 3'b000, 3'b000);
      #23;
      checkOutput("rst_busy", {29'd0, a_busy}, 32'd0);
      checkOutput("rst_done", {29'd0, a_done}, 32'd0);
      checkOutput("rst_kl",   {29'd0, a_kl},   32'd0);
      checkOutput("rst_ka",   {31'd0, a_ka},   32'd0);
      reset_n = 1'b1;
      tick();

      // basic delay of 5 on ch0
      setCfg(0, 0, 8'd5);
      e = now + 1;
      pushExp(0, 0, e + 5);
      applyStimulus(0, 3'b001, 3'b000, 3'b000);
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k == 0) applyStimulus(0, 3'b000, 3'b000, 3'b000);
         checkOutput($sformatf("s1_busy_k%0d", k), {31'd0, a_busy[0]}, (k < 5) ? 32'd1 : 32'd0);
      end
      tick();

      // kill mid-run on ch1, sticky flag until cleared
      setCfg(0, 1, 8'd8);
      applyStimulus(0, 3'b010, 3'b000, 3'b000);
      tick();
      applyStimulus(0, 3'b000, 3'b000, 3'b000);
      tick();
      tick();
      checkOutput("s2_busy_pre", {31'd0, a_busy[1]}, 32'd1);
      applyStimulus(0, 3'b000, 3'b010, 3'b000);
      tick();
      applyStimulus(0, 3'b000, 3'b000, 3'b000);
      checkOutput("s2_busy_kill", {31'd0, a_busy[1]}, 32'd0);
      checkOutput("s2_kl",        {29'd0, a_kl},      32'd2);
      checkOutput("s2_ka",        {31'd0, a_ka},      32'd1);
      for (int k = 0; k < 10; k++) tick();
      checkOutput("s2_kl_hold", {29'd0, a_kl}, 32'd2);
      applyStimulus(0, 3'b000, 3'b000, 3'b010);
      tick();
      applyStimulus(0, 3'b000, 3'b000, 3'b000);
      checkOutput("s2_kl_clr", {29'd0, a_kl}, 32'd0);
      checkOutput("s2_ka_clr", {31'd0, a_ka}, 32'd0);

      // second go two edges later: ignored on A, restarts the delay on B
      setCfg(0, 0, 8'd4);
      setCfg(1, 0, 8'd4);
      e = now + 1;
      pushExp(0, 0, e + 4);
      pushExp(1, 0, e + 6);
      applyStimulus(0, 3'b001, 3'b000, 3'b000);
      applyStimulus(1, 3'b001, 3'b000, 3'b000);
      tick();
      applyStimulus(0, 3'b000, 3'b000, 3'b000);
      applyStimulus(1, 3'b000, 3'b000, 3'b000);
      tick();
      applyStimulus(0, 3'b001, 3'b000, 3'b000);
      applyStimulus(1, 3'b001, 3'b000, 3'b000);
      tick();
      applyStimulus(0, 3'b000, 3'b000, 3'b000);
      applyStimulus(1, 3'b000, 3'b000, 3'b000);
      for (int k = 0; k < 3; k++) tick();
      checkOutput("s3_a_idle", {31'd0, a_busy[0]}, 32'd0);
      checkOutput("s3_b_run",  {31'd0, b_busy[0]}, 32'd1);
      for (int k = 0; k < 5; k++) tick();

      // zero delay behaves as one
      setCfg(0, 2, 8'd0);
      e = now + 1;
      pushExp(0, 2, e + 1);
      applyStimulus(0, 3'b100, 3'b000, 3'b000);
      tick();
      applyStimulus(0, 3'b000, 3'b000, 3'b000);
      checkOutput("s4_zero_busy", {31'd0, a_busy[2]}, 32'd1);
      tick();
      tick();

      // go held high: RUN and DONE alternate
      setCfg(0, 0, 8'd1);
      e = now + 1;
      for (int k = 1; k < 8; k += 2) pushExp(0, 0, e + k);
      applyStimulus(0, 3'b001, 3'b000, 3'b000);
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 7) applyStimulus(0, 3'b000, 3'b000, 3'b000);
         checkOutput($sformatf("s4_hold_busy_k%0d", k), {31'd0, a_busy[0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      tick();
      checkOutput("s4_hold_end", {31'd0, a_busy[0]}, 32'd0);

      // kill beats go in IDLE; kill beats a simultaneous clear
      applyStimulus(0, 3'b100, 3'b100, 3'b000);
      tick();
      checkOutput("s4_killgo_busy", {31'd0, a_busy[2]}, 32'd0);
      checkOutput("s4_killgo_kl",   {29'd0, a_kl},      32'd4);
      applyStimulus(0, 3'b000, 3'b001, 3'b001);
      tick();
      checkOutput("s4_killclr_kl", {29'd0, a_kl}, 32'd5);
      applyStimulus(0, 3'b000, 3'b000, 3'b101);
      tick();
      applyStimulus(0, 3'b000, 3'b000, 3'b000);
      checkOutput("s4_clr_kl", {29'd0, a_kl}, 32'd0);
      checkOutput("s4_clr_ka", {31'd0, a_ka}, 32'd0);
      for (int k = 0; k < 3; k++) tick();

      // two channels at once; cfg change during RUN must not matter
      setCfg(0, 0, 8'd2);
      setCfg(0, 1, 8'd3);
      e = now + 1;
      pushExp(0, 0, e + 2);
      pushExp(0, 1, e + 3);
      applyStimulus(0, 3'b011, 3'b000, 3'b000);
      tick();
      applyStimulus(0, 3'b000, 3'b000, 3'b000);
      setCfg(0, 1, 8'd20);
      for (int k = 0; k < 5; k++) tick();

      // reset during RUN of all channels
      applyStimulus(1, 3'b000, 3'b100, 3'b000);
      tick();
      applyStimulus(1, 3'b000, 3'b000, 3'b000);
      checkOutput("s5_b_kl_pre", {29'd0, b_kl}, 32'd4);
      setCfg(0, 0, 8'd10);
      setCfg(0, 1, 8'd10);
      setCfg(0, 2, 8'd10);
      applyStimulus(0, 3'b111, 3'b000, 3'b000);
      tick();
      applyStimulus(0, 3'b000, 3'b000, 3'b000);
      tick();
      tick();
      checkOutput("s5_busy_pre", {29'd0, a_busy}, 32'd7);
      reset_n = 1'b0;
      #2;
      checkOutput("s5_rst_busy", {29'd0, a_busy}, 32'd0);
      checkOutput("s5_rst_done", {29'd0, a_done}, 32'd0);
      checkOutput("s5_rst_b_kl", {29'd0, b_kl},   32'd0);
      checkOutput("s5_rst_b_ka", {31'd0, b_ka},   32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      checkOutput("s5_post_busy", {29'd0, a_busy}, 32'd0);
      setCfg(0, 0, 8'd3);
      e = now + 1;
      pushExp(0, 0, e + 3);
      applyStimulus(0, 3'b001, 3'b000, 3'b000);
      tick();
      applyStimulus(0, 3'b000, 3'b000, 3'b000);
      checkOutput("s5_restart_busy", {29'd0, a_busy}, 32'd1);
      for (int k = 0; k < 12; k++) tick();

      checkOutput("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_go_delay.md
MULTI_GO_DELAY -- requirements
Module: multi_go_delay

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, giving the number of independent go/delay channels (1..16).
REQ-002 The block SHALL have parameter DLY_W, default 8, giving the width of each channel's delay count.
REQ-003 The block SHALL have parameter RETRIG, default 0; 1 = go during RUN restarts the delay, 0 = go during RUN is ignored.
REQ-004 The block SHALL have these ports, clock and reset first:
 clk  in  1  single clock; all state changes on its rising edge
 reset_n  in  1  asynchronous, active-low reset
 go  in  NUM_CH  per-channel start request, sampled each clk edge
 kill  in  NUM_CH  per-channel abort request
 kill_clr  in  NUM_CH  per-channel clear of the latched kill flag
 delay_cfg  in  NUM_CH*DLY_W  per-channel delay; channel i uses bits [i*DLY_W +: DLY_W]
 busy  out  NUM_CH  channel i is in RUN
 done  out  NUM_CH  one-cycle completion pulse per channel
 kill_ltchd  out  NUM_CH  sticky per-channel kill flag
 kill_any  out  1  OR of all kill_ltchd bits
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset (reset_n); no other clock or reset SHALL exist.

Function
REQ-006 Each channel SHALL run an independent FSM with states IDLE, RUN, DONE.
REQ-007 In IDLE, go=1 and kill=0 SHALL load the counter with delay_cfg (0 treated as 1) and move to RUN.
REQ-008 In RUN, the counter SHALL decrement once per cycle; when it reaches 1 with kill=0, the FSM SHALL move to DONE.
REQ-009 done SHALL be registered and high only in DONE; with go sampled at edge E, done SHALL be high for exactly the cycle after edge E+delay_cfg.
REQ-010 DONE SHALL last one cycle: go=1 and kill=0 SHALL reload and enter RUN (back-to-back); otherwise the FSM SHALL return to IDLE.
REQ-011 In RUN, kill=1 SHALL return the FSM to IDLE on the next edge; done SHALL NOT assert for that run.
REQ-012 kill SHALL have priority over go in every state; kill in IDLE or DONE SHALL force IDLE.
REQ-013 With RETRIG=1, go=1 and kill=0 in RUN SHALL reload the counter from the current delay_cfg and stay in RUN; with RETRIG=0, such go SHALL be ignored.
REQ-014 delay_cfg SHALL be sampled only at load; changes during RUN SHALL have no effect.
REQ-015 busy[i] SHALL be 1 exactly while channel i is in RUN.
REQ-016 kill_ltchd[i] SHALL set on any cycle with kill[i]=1 and clear on kill_clr[i]=1; set SHALL win when both are high.
REQ-017 kill_ltchd[i] SHALL be independent of FSM state and hold until cleared or reset.
REQ-018 kill_any SHALL be the combinational OR of kill_ltchd.
REQ-019 Channels SHALL NOT interact; simultaneous events on different channels SHALL be handled independently in the same cycle.

Reset
REQ-020 reset_n=0 SHALL immediately and asynchronously force all FSMs to IDLE, counters to 0, and done, busy, kill_ltchd and kill_any to 0.
REQ-021 Reset asserted mid-RUN SHALL abort the run with no done pulse; the first go after reset_n deasserts SHALL start a fresh delay.
REQ-022 Reset deassertion SHALL be synchronised to clk outside this block; the block SHALL sample no inputs while reset_n=0.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default DLY_W.
REQ-024 The per-channel FSM and counter SHALL be one sub-module, go_delay_ch (parameters DLY_W, RETRIG), instantiated NUM_CH times by a generate loop.
REQ-025 The kill latches and kill_any SHALL live in the top level, multi_go_delay.

Verification
REQ-026 Delay: ch0 delay_cfg=5, one-cycle go at edge 10 -> busy[0] high cycles 10-14, done[0] a single pulse after edge 15.
REQ-027 Kill mid-run: ch1 delay_cfg=8, go at edge 0, kill at edge 3 -> busy[1] drops after edge 3, no done[1], kill_ltchd[1]=1 and kill_any=1 until kill_clr[1].
REQ-028 Retrigger: RETRIG=1, delay_cfg=4, go at edges 0 and 2 -> done after edge 6 only; with RETRIG=0 -> done after edge 4 only.
REQ-029 Boundary: delay_cfg=0 behaves as 1; go held high -> done every second cycle (RUN, DONE alternating); kill and kill_clr together -> kill_ltchd stays 1.
REQ-030 Reset mid-run: reset_n low for 2 cycles during RUN of all NUM_CH=3 channels -> all outputs 0 at once, no done, normal operation after release.
